// File: rtl/apb_bus_arbiter_pkg.sv
// Shared types and defaults for the two-requester APB bus arbiter.
// FSM state encoding, default geometry and bank-field helpers.
package apb_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2,
    StResp   = 2'd3
  } state_e;

  localparam int unsigned DefBankNum    = 2;
  localparam int unsigned DefAddrWidth  = 7;
  localparam int unsigned DefPdataWidth = 8;
  localparam int unsigned DefPaddrWidth = 3;
  localparam int unsigned DefTimeout    = 15;

  // Bank field sits directly above the APB offset bits.
  function automatic int unsigned bank_width(int unsigned bank_num);
    return (bank_num > 1) ? $clog2(bank_num) : 1;
  endfunction

  localparam int unsigned BankFieldLsb   = DefPaddrWidth;
  localparam int unsigned BankFieldWidth = bank_width(DefBankNum);

endpackage

// File: rtl/apb_bus_arbiter_if.sv
// Requester handshake and APB bank-bus signals of the arbiter.
// master = arbiter side, slave = requesters plus bank slaves.
interface apb_bus_arbiter_if #(
  parameter int unsigned BANK_NUM    = 2,
  parameter int unsigned ADDR_WIDTH  = 7,
  parameter int unsigned PDATA_WIDTH = 8,
  parameter int unsigned PADDR_WIDTH = 3
);

  logic                   r0_valid;
  logic                   r1_valid;
  logic                   r0_write;
  logic                   r1_write;
  logic [ADDR_WIDTH-1:0]  r0_addr;
  logic [ADDR_WIDTH-1:0]  r1_addr;
  logic [PDATA_WIDTH-1:0] r0_wdata;
  logic [PDATA_WIDTH-1:0] r1_wdata;
  logic                   r0_grant;
  logic                   r1_grant;
  logic                   r0_done;
  logic                   r1_done;
  logic [PDATA_WIDTH-1:0] rsp_rdata;
  logic                   rsp_err;
  logic                   busy;

  logic [BANK_NUM-1:0]    b_psel;
  logic                   b_penable;
  logic                   b_pwrite;
  logic [PADDR_WIDTH-1:0] b_paddr;
  logic [PDATA_WIDTH-1:0] b_pwdata;
  logic [PDATA_WIDTH-1:0] b_prdata;
  logic                   b_pready;

  modport master (
    input  r0_valid, r1_valid, r0_write, r1_write, r0_addr, r1_addr, r0_wdata, r1_wdata,
    input  b_prdata, b_pready,
    output r0_grant, r1_grant, r0_done, r1_done, rsp_rdata, rsp_err, busy,
    output b_psel, b_penable, b_pwrite, b_paddr, b_pwdata
  );

  modport slave (
    output r0_valid, r1_valid, r0_write, r1_write, r0_addr, r1_addr, r0_wdata, r1_wdata,
    output b_prdata, b_pready,
    input  r0_grant, r1_grant, r0_done, r1_done, rsp_rdata, rsp_err, busy,
    input  b_psel, b_penable, b_pwrite, b_paddr, b_pwdata
  );

endinterface

// File: rtl/apb_rr_arb2.sv
// Two-input round-robin picker; the pointer remembers the last granted requester
// and resets to 1 so requester 0 wins the first tie.
module apb_rr_arb2 (
  input  logic       clk,
  input  logic       resetn,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] gnt,
  output logic       owner
);

  logic last_q, last_d;

  always_comb begin
    gnt    = 2'b00;
    owner  = 1'b0;
    last_d = last_q;
    if (en) begin
      case (valid)
        2'b01:   owner = 1'b0;
        2'b10:   owner = 1'b1;
        2'b11:   owner = ~last_q;
        default: owner = 1'b0;
      endcase
      if (valid != 2'b00) begin
        gnt    = owner ? 2'b10 : 2'b01;
        last_d = owner;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/apb_bus_arbiter.sv
// Shares one APB bank bus between two register requesters: round-robin grant,
// address decode to a one-hot bank select, SETUP/ACCESS sequencing and response.
module apb_bus_arbiter
  import apb_bus_arbiter_pkg::*;
#(
  parameter int unsigned BANK_NUM    = DefBankNum,
  parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
  parameter int unsigned PDATA_WIDTH = DefPdataWidth,
  parameter int unsigned PADDR_WIDTH = DefPaddrWidth,
  parameter int unsigned TIMEOUT     = DefTimeout
) (
  input logic               clk,
  input logic               resetn,
  apb_bus_arbiter_if.master bus
);

  localparam int unsigned BankW = bank_width(BANK_NUM);
  localparam int unsigned HiLsb = PADDR_WIDTH + BankW;
  localparam int unsigned CntW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e                 state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   write_q, write_d;
  logic [BankW-1:0]       bank_q, bank_d;
  logic [PADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [PDATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [PDATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                   err_q, err_d;

  logic [1:0]             arb_gnt;
  logic                   arb_owner;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic [BankW-1:0]       req_bank;
  logic                   dec_err;
  logic [BANK_NUM-1:0]    sel_vec;
  logic [BANK_NUM-1:0]    psel;
  logic                   penable;

  // Reset gates the enable so no grant pulse escapes while resetn is low.
  apb_rr_arb2 u_arb (
    .clk    (clk),
    .resetn (resetn),
    .en     ((state_q == StIdle) && resetn),
    .valid  ({bus.r1_valid, bus.r0_valid}),
    .gnt    (arb_gnt),
    .owner  (arb_owner)
  );

  always_comb begin
    req_addr = arb_owner ? bus.r1_addr : bus.r0_addr;
    req_bank = req_addr[PADDR_WIDTH +: BankW];
    dec_err  = ((req_addr >> HiLsb) != '0) || (32'(req_bank) >= BANK_NUM);
    for (int unsigned i = 0; i < BANK_NUM; i++) begin
      sel_vec[i] = (bank_q == BankW'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    write_d = write_q;
    bank_d  = bank_q;
    paddr_d = paddr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    psel    = '0;
    penable = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arb_gnt != 2'b00) begin
          owner_d = arb_owner;
          write_d = arb_owner ? bus.r1_write : bus.r0_write;
          wdata_d = arb_owner ? bus.r1_wdata : bus.r0_wdata;
          paddr_d = req_addr[PADDR_WIDTH-1:0];
          bank_d  = req_bank;
          cnt_d   = '0;
          if (dec_err) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = StResp;
          end else begin
            state_d = StSetup;
          end
        end
      end
      StSetup: begin
        psel    = sel_vec;
        state_d = StAccess;
      end
      StAccess: begin
        psel    = sel_vec;
        penable = 1'b1;
        if (bus.b_pready) begin
          rdata_d = write_q ? '0 : bus.b_prdata;
          err_d   = 1'b0;
          state_d = StResp;
        end else if ((TIMEOUT != 0) && (cnt_q == CntLast)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      write_q <= 1'b0;
      bank_q  <= '0;
      paddr_q <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      write_q <= write_d;
      bank_q  <= bank_d;
      paddr_q <= paddr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    bus.r0_grant  = arb_gnt[0];
    bus.r1_grant  = arb_gnt[1];
    bus.r0_done   = (state_q == StResp) && !owner_q;
    bus.r1_done   = (state_q == StResp) && owner_q;
    bus.rsp_rdata = rdata_q;
    bus.rsp_err   = err_q;
    bus.busy      = (state_q != StIdle);
    bus.b_psel    = psel;
    bus.b_penable = penable;
    bus.b_pwrite  = write_q;
    bus.b_paddr   = paddr_q;
    bus.b_pwdata  = wdata_q;
  end

endmodule

// File: doc/apb_bus_arbiter.md
Name: apb_bus_arbiter

Overview:
- Shares the GPIO-expander APB bus between two register-access requesters: requester 0 is the SPI frame engine, requester 1 is the local status/interrupt poller.
- Arbitrates round-robin and decodes the 7-bit register address into a one-hot bank select plus the APB offset.
- Runs the APB SETUP/ACCESS sequence and returns read data or an error to the granted requester.
- Sits between the SPI front end and the apb bank slaves.

Parameters:
- BANK_NUM, 2, number of APB banks; psel width.
- ADDR_WIDTH, 7, requester address width.
- PDATA_WIDTH, 8, APB data width.
- PADDR_WIDTH, 3, APB offset width, taken from addr[PADDR_WIDTH-1:0].
- TIMEOUT, 15, maximum ACCESS cycles with pready low before abort; 0 disables the timeout.

Ports:
- clk  in  1  single clock.
- resetn  in  1  asynchronous, active-low reset.
- r0_valid / r1_valid  in  1  request pending; held until grant.
- r0_write / r1_write  in  1  1 = write, 0 = read.
- r0_addr / r1_addr  in  ADDR_WIDTH  register address.
- r0_wdata / r1_wdata  in  PDATA_WIDTH  write data.
- r0_grant / r1_grant  out  1  one-cycle pulse: request accepted and fields latched.
- r0_done / r1_done  out  1  one-cycle pulse: transaction finished.
- rsp_rdata  out  PDATA_WIDTH  read data; valid while any done is high.
- rsp_err  out  1  error flag; valid while any done is high.
- busy  out  1  high in every state except IDLE.
- b_psel  out  BANK_NUM  one-hot APB select.
- b_penable  out  1  APB enable.
- b_pwrite  out  1  APB direction.
- b_paddr  out  PADDR_WIDTH  APB address.
- b_pwdata  out  PDATA_WIDTH  APB write data.
- b_prdata  in  PDATA_WIDTH  APB read data.
- b_pready  in  1  APB ready.

Behaviour:
- Reset (resetn low, async): state = IDLE; all outputs 0; last-grant pointer = 1, so r0 wins the first tie.
- Reset mid-transfer drops psel and penable immediately. No done pulse is issued for the aborted transfer.
- States are IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - Grants happen only in IDLE.
  - If one valid is high, that requester is granted.
  - If both are high, the requester not granted last wins; the pointer updates on every grant.
  - On grant: pulse rN_grant; latch write, addr and wdata; record the owner.
  - Bank index = addr[PADDR_WIDTH +: clog2(BANK_NUM)].
  - Any addr bit above the bank field set, or bank index >= BANK_NUM, is a decode error: go to RESP with err=1. No APB activity occurs.
  - Otherwise go to SETUP.
- SETUP (1 cycle): psel[bank]=1, penable=0; paddr, pwrite and pwdata driven from the latched values. Go to ACCESS.
- ACCESS:
  - psel and penable both high; address, control and data held stable.
  - On b_pready=1: capture prdata (read) or 0 (write); err=0; go to RESP.
  - Wait counter counts ACCESS cycles with pready low. When it reaches TIMEOUT: err=1, rdata=0, go to RESP.
- RESP (1 cycle):
  - psel and penable are 0.
  - rN_done pulses for the owner only; rsp_rdata and rsp_err are valid in this cycle.
  - Go to IDLE.
- rsp_rdata and rsp_err hold their value until the next RESP.
- Latency from grant cycle to done:
  - zero-wait-state transfer: 3 cycles (SETUP, ACCESS, RESP);
  - each wait state adds 1 cycle;
  - decode error: 1 cycle.
- Back-to-back: minimum 4 cycles per transfer. A requester still valid in IDLE is granted in that cycle.
- Valid arriving while busy is not granted and is not lost; the requester keeps it asserted.
- Valid dropped before grant is ignored; no grant is issued for it.
- grant and done never pulse for both requesters in the same cycle.

Decomposition:
- Shared package/header holds:
  - state encodings (IDLE=0, SETUP=1, ACCESS=2, RESP=3);
  - bank-field position and width;
  - default TIMEOUT.
- Sub-module apb_rr_arb2: two-input round-robin picker with pointer register. Inputs are valid[1:0] and an enable (IDLE); outputs are the grant one-hot and the owner index.

Test Plan:
- Single write, r0 addr 7'h0A, wdata 8'hA5, pready tied 1 → grant at T; psel=2'b10, paddr=3'h2 at T+1, penable at T+2; r0_done at T+3 with err=0.
- Read, r1 addr 7'h03, slave drives prdata 8'h5C with 2 wait states → done at T+5, rsp_rdata=8'h5C, err=0; r0 never granted.
- r0 and r1 valid together, held continuously for 4 transfers → grants in order r0, r1, r0, r1, 4 cycles apart.
- r0 addr 7'h7F → no psel activity; r0_done one cycle after grant with err=1.
- pready held 0, TIMEOUT=15 → abort after 15 ACCESS cycles; done with err=1, rdata=8'h00; psel low in RESP.
- resetn pulsed low during ACCESS → psel, penable, busy and done are 0 immediately; after release a pending r1 request is granted normally.
